// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port fixed-latency memory between fetch (if_*) and data (dm_*) requesters.
// Latency : grant edge k, mem_en high for cycle k..k+1, rdata captured and ack pulsed at edge k+LATENCY.
// Backpr. : requesters hold req until their one-cycle ack; stall_if/stall_dm = req & ~ack. Optional stats: ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int WIDTH         = 32,
    parameter int ADDR_W        = 8,
    parameter int LATENCY       = 2,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [WIDTH-1:0]  if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [WIDTH-1:0]  dm_wdata,
    output logic              dm_ack,
    output logic [WIDTH-1:0]  dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              stall_if,
    output logic              stall_dm,
`ifdef ARB_STATS_EN
    output logic [15:0]       stat_if_cnt,
    output logic [15:0]       stat_dm_cnt,
`endif
    output logic              busy
);

    localparam logic [2:0] LAT_CNT    = 3'(LATENCY);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [2:0]        cnt, cnt_d;
    logic [3:0]        streak, streak_d;
    logic              owner_dm, owner_dm_d;
    logic              owner_we, owner_we_d;
    logic              mem_en_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_d;
    logic              if_ack_d, dm_ack_d;
    logic [WIDTH-1:0]  if_rdata_d, dm_rdata_d;
    logic              grant_if, grant_dm;

    // Next-state, arbitration and registered-output values.
    // A request seen during its own ack cycle is already the requester's next
    // access; the FSM is back in IDLE then, so it is granted at the following edge.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        streak_d    = streak;
        owner_dm_d  = owner_dm;
        owner_we_d  = owner_we;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;

        case (state)
            IDLE: begin
                // dm normally wins a tie; a saturated streak hands the slot to fetch.
                if (if_req && (!dm_req || streak == STREAK_MAX)) begin
                    grant_if = 1'b1;
                end else if (dm_req) begin
                    grant_dm = 1'b1;
                end

                if (grant_if) begin
                    owner_dm_d  = 1'b0;
                    owner_we_d  = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    streak_d    = 4'd0;
                    cnt_d       = LAT_CNT;
                    state_d     = WAIT;
                end else if (grant_dm) begin
                    owner_dm_d  = 1'b1;
                    owner_we_d  = dm_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    // Only a contested dm grant lengthens the streak.
                    if (if_req) begin
                        streak_d = (streak == STREAK_MAX) ? streak : streak + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                    cnt_d   = LAT_CNT;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                cnt_d = cnt - 3'd1;
                // cnt == 1 marks edge k+LATENCY: memory data is valid now.
                if (cnt == 3'd1) begin
                    state_d = IDLE;
                    if (owner_dm) begin
                        dm_ack_d = 1'b1;
                        if (!owner_we) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            streak    <= 4'd0;
            owner_dm  <= 1'b0;
            owner_we  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            streak    <= streak_d;
            owner_dm  <= owner_dm_d;
            owner_we  <= owner_we_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_ack    <= if_ack_d;
            dm_ack    <= dm_ack_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
        end
    end

    assign stall_if = if_req & ~if_ack;
    assign stall_dm = dm_req & ~dm_ack;
    assign busy     = (state != IDLE);

`ifdef ARB_STATS_EN
    // Saturating grant counters per requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_cnt <= 16'd0;
            stat_dm_cnt <= 16'd0;
        end else begin
            if (grant_if && stat_if_cnt != 16'hFFFF) begin
                stat_if_cnt <= stat_if_cnt + 16'd1;
            end
            if (grant_dm && stat_dm_cnt != 16'hFFFF) begin
                stat_dm_cnt <= stat_dm_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : randomized and directed bench for mem_port_arbiter against a transaction-level model.
// Latency : model schedules each grant's ack at grant+LATENCY and the next slot one edge later.
// Backpr. : requester agents hold req until ack; stall outputs are compared every cycle.
module tb_mem_port_arbiter;

    localparam int W    = 32;
    localparam int AW   = 8;
    localparam int LAT  = 2;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [W-1:0]  if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [W-1:0]  dm_wdata;
    logic          dm_ack;
    logic [W-1:0]  dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          stall_if;
    logic          stall_dm;
    logic          busy;
`ifdef ARB_STATS_EN
    logic [15:0]   stat_if_cnt;
    logic [15:0]   stat_dm_cnt;
`endif

    mem_port_arbiter #(
        .WIDTH(W), .ADDR_W(AW), .LATENCY(LAT), .MAX_DM_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_dm(stall_dm),
`ifdef ARB_STATS_EN
        .stat_if_cnt(stat_if_cnt), .stat_dm_cnt(stat_dm_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory with LATENCY=2: address sampled at edge k+1, data valid until edge k+2 only.
    logic [W-1:0] seed_arr [256];
    logic [W-1:0] mem_arr  [256];
    logic         mem_init;
    logic [W-1:0] rd_q;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= seed_arr[i];
            rd_q <= '0;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            rd_q <= mem_arr[mem_addr];
        end else begin
            rd_q <= 32'hBAD0BAD0;
        end
    end
    assign mem_rdata = rd_q;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [W-1:0] refmem [256];
    int           edge_n  = 0;
    int           free_at = 0;
    int           ack_at  = 0;
    bit           act     = 0;
    bit           own_dm, own_we;
    logic [W-1:0] own_rd;
    int           streak_m = 0;
    bit           e_if_ack, e_dm_ack, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [W-1:0] e_wdata;
    logic [W-1:0] e_if_rd = '0;
    logic [W-1:0] e_dm_rd = '0;
    int           e_if_n = 0;
    int           e_dm_n = 0;

    task automatic model_reset();
        act = 0; free_at = 0; streak_m = 0;
        e_if_rd = '0; e_dm_rd = '0; e_if_n = 0; e_dm_n = 0;
    endtask

    // Processes edge edge_n using the request inputs seen at that edge.
    task automatic model_edge();
        bit take_if;
        e_if_ack = 0; e_dm_ack = 0; e_en = 0; e_we = 0;
        if (act && edge_n == ack_at) begin
            act = 0;
            if (own_dm) begin
                e_dm_ack = 1;
                if (!own_we) e_dm_rd = own_rd;
            end else begin
                e_if_ack = 1;
                e_if_rd  = own_rd;
            end
        end else if (!act && edge_n >= free_at && (if_req || dm_req)) begin
            take_if = if_req && (!dm_req || streak_m == MAXS);
            if (take_if) begin
                own_dm = 0; own_we = 0; e_addr = if_addr; e_wdata = '0;
                streak_m = 0;
                if (e_if_n < 65535) e_if_n++;
            end else begin
                own_dm = 1; own_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
                streak_m = if_req ? ((streak_m + 1 > MAXS) ? MAXS : streak_m + 1) : 0;
                if (e_dm_n < 65535) e_dm_n++;
            end
            own_rd = refmem[e_addr];
            if (own_we) refmem[e_addr] = e_wdata;
            act = 1; e_en = 1; e_we = own_we;
            ack_at  = edge_n + LAT;
            free_at = ack_at + 1;
        end
    endtask

    // ---------------- requester agents ----------------
    int  if_mode = 0;   // 0 manual, 1 random, 2 back-to-back
    int  dm_mode = 0;
    bit  loads_only = 0;

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = 8'($urandom_range(0, 15));
    endtask

    task automatic new_dm();
        dm_req   = 1'b1;
        dm_we    = loads_only ? 1'b0 : 1'($urandom_range(0, 1));
        dm_addr  = 8'($urandom_range(0, 15));
        dm_wdata = $urandom;
    endtask

    task automatic agents();
        if (if_req && e_if_ack) begin
            if (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 1) == 1)) new_if();
            else if_req = 1'b0;
        end else if (!if_req && (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 3) == 0))) begin
            new_if();
        end
        if (dm_req && e_dm_ack) begin
            if (dm_mode == 2 || (dm_mode == 1 && $urandom_range(0, 1) == 1)) new_dm();
            else dm_req = 1'b0;
        end else if (!dm_req && (dm_mode == 2 || (dm_mode == 1 && $urandom_range(0, 3) == 0))) begin
            new_dm();
        end else if (dm_req && dm_mode == 1 && $urandom_range(0, 7) == 0) begin
            // Pending data request may change its payload; the grant-edge value counts.
            dm_addr  = 8'($urandom_range(0, 15));
            dm_wdata = $urandom;
        end
    endtask

    // One clock: model the edge, compare outputs, then move the agents.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        model_edge();
        chk("if_ack", if_ack, e_if_ack);
        chk("dm_ack", dm_ack, e_dm_ack);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        end
        chk("if_rdata", if_rdata, e_if_rd);
        chk("dm_rdata", dm_rdata, e_dm_rd);
        chk("busy", busy, act);
`ifdef ARB_STATS_EN
        chk("stat_if_cnt", stat_if_cnt, 64'(e_if_n));
        chk("stat_dm_cnt", stat_dm_cnt, 64'(e_dm_n));
`endif
        agents();
        #1;
        chk("stall_if", stall_if, if_req & ~e_if_ack);
        chk("stall_dm", stall_dm, dm_req & ~e_dm_ack);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_ack", if_ack, 0);
        chk("rst_dm_ack", dm_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int t_a, t_b, t_if, t_dm, t0, en_cnt, nacks, got;
        logic [63:0] seq;

        rst = 1'b1; mem_init = 1'b1;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 256; i++) seed_arr[i] = $urandom;
        seed_arr[3] = 32'hDEAD0003;
        for (int i = 0; i < 256; i++) refmem[i] = seed_arr[i];
        do_reset();
        mem_init = 1'b0;

        // Lone fetch: grant at edge 1, ack after edge 3.
        if_req = 1'b1; if_addr = 8'h03;
        t_a = -1; en_cnt = 0;
        for (int i = 1; i <= 10 && t_a < 0; i++) begin
            tick();
            if (mem_en) en_cnt++;
            if (if_ack) t_a = i;
        end
        chk("t1_ack_edge", 64'(t_a), 64'd3);
        chk("t1_mem_en_cycles", 64'(en_cnt), 64'd1);
        chk("t1_rdata", if_rdata, 32'hDEAD0003);

        // Store then load at the same address.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 32'h00000055;
        t_a = -1;
        for (int i = 0; i < 20 && t_a < 0; i++) begin
            tick();
            if (dm_ack) t_a = edge_n;
        end
        dm_req = 1'b1; dm_we = 1'b0;
        t_b = -1;
        for (int i = 0; i < 20 && t_b < 0; i++) begin
            tick();
            if (dm_ack) t_b = edge_n;
        end
        chk("t2_ack_gap", 64'(t_b - t_a), 64'd3);
        chk("t2_load_data", dm_rdata, 32'h00000055);

        // Simultaneous requests in IDLE: dm first, fetch three cycles later.
        repeat (2) tick();
        t0 = edge_n;
        new_if(); new_dm();
        t_if = -1; t_dm = -1;
        for (int i = 0; i < 20 && (t_if < 0 || t_dm < 0); i++) begin
            tick();
            if (dm_ack) t_dm = edge_n;
            if (if_ack) t_if = edge_n;
        end
        chk("t3_dm_latency", 64'(t_dm - t0), 64'd3);
        chk("t3_if_after_dm", 64'(t_if - t_dm), 64'd3);

        // Reset when cnt==1 during a load aborts it; request is served again afterwards.
        repeat (2) tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h05;
        tick();   // grant edge
        tick();   // cnt now 1
        #1 rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_mem_en", mem_en, 0);
        chk("t5_dm_ack", dm_ack, 0);
        do_reset();
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick();
            if (dm_ack) got = 1;
        end
        chk("t5_reserved", 64'(got), 64'd1);
        chk("t5_load_data", dm_rdata, refmem[5]);

        // Starvation guard: back-to-back loads against a held fetch.
        if_req = 1'b0; dm_req = 1'b0;
        do_reset();
        loads_only = 1; if_mode = 2; dm_mode = 2;
        new_if(); new_dm();
        seq = '0; nacks = 0;
        for (int i = 0; i < 60 && nacks < 6; i++) begin
            tick();
            if (dm_ack) begin seq = {seq[62:0], 1'b0}; nacks++; end
            if (if_ack) begin
                seq = {seq[62:0], 1'b1}; nacks++;
`ifdef ARB_STATS_EN
                chk("t6_stat_dm", stat_dm_cnt, 64'd4);
                chk("t6_stat_if", stat_if_cnt, 64'd1);
`endif
            end
        end
        chk("t4_ack_count", 64'(nacks), 64'd6);
        chk("t4_ack_order", seq, 64'b000010);
        loads_only = 0;

        // Randomized traffic in several mixes.
        if_mode = 1; dm_mode = 1;
        repeat (400) tick();
        if_mode = 2; dm_mode = 2;
        repeat (100) tick();
        if_mode = 2; dm_mode = 1;
        repeat (100) tick();
        if_mode = 1; dm_mode = 2;
        repeat (100) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
